// File: rtl/timer_counter.sv
// timer_counter: memory-mapped down-counting timer with a maskable interrupt.
// Register map (word addressed): 0 = CTRL {IM, MODE[1:0], EN}, 1 = PRESET,
// 2 = COUNT (read-only), 3 = reads zero. Reads are combinational.
module timer_counter #(
    parameter int WIDTH = 32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  addr,
    input  logic        we,
    input  logic [3:0]  byte_en,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        irq
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        CNT  = 2'd2,
        INT  = 2'd3
    } state_t;

    state_t             r_state;
    state_t             w_next_state;
    logic               r_en;
    logic [1:0]         r_mode;
    logic               r_im;
    logic [WIDTH-1:0]   r_preset;
    logic [WIDTH-1:0]   r_count;
    logic               r_irq_flag;

    logic               w_ctrl_wr;
    logic               w_preset_wr;
    logic [31:0]        w_preset_ext;
    logic [31:0]        w_count_ext;
    logic [31:0]        w_preset_merged;
    logic               w_fsm_load;
    logic               w_fsm_dec;
    logic               w_fsm_set_irq;
    logic               w_fsm_clr_irq;
    logic               w_fsm_clr_en;

    // CTRL only has fields in byte 0, so only byte_en[0] makes a CTRL write count.
    assign w_ctrl_wr   = we && (addr == 2'd0) && byte_en[0];
    assign w_preset_wr = we && (addr == 2'd1);

    // Zero-extend PRESET/COUNT to the bus width and merge byte-enabled store data into PRESET.
    always_comb begin
        w_preset_ext = '0;
        w_count_ext  = '0;
        w_preset_ext[WIDTH-1:0] = r_preset;
        w_count_ext[WIDTH-1:0]  = r_count;
        w_preset_merged = w_preset_ext;
        for (int i = 0; i < 4; i++) begin
            if (byte_en[i]) begin
                w_preset_merged[8*i +: 8] = wdata[8*i +: 8];
            end
        end
    end

    // Combinational read mux; a same-cycle write is not visible until the next edge.
    always_comb begin
        rdata = '0;
        case (addr)
            2'd0:    rdata = {28'd0, r_im, r_mode, r_en};
            2'd1:    rdata = w_preset_ext;
            2'd2:    rdata = w_count_ext;
            default: rdata = '0;
        endcase
    end

    assign irq = r_irq_flag & r_im;

    // Next-state and datapath control: IDLE -> LOAD -> CNT (down to zero) -> INT.
    always_comb begin
        w_next_state  = r_state;
        w_fsm_load    = 1'b0;
        w_fsm_dec     = 1'b0;
        w_fsm_set_irq = 1'b0;
        w_fsm_clr_irq = 1'b0;
        w_fsm_clr_en  = 1'b0;
        case (r_state)
            IDLE: begin
                if (r_en) begin
                    w_next_state = LOAD;
                end
            end
            LOAD: begin
                w_fsm_load   = 1'b1;
                w_next_state = CNT;
            end
            CNT: begin
                if (!r_en) begin
                    w_next_state = IDLE;
                end else if (r_count == '0) begin
                    w_fsm_set_irq = 1'b1;
                    w_next_state  = INT;
                end else begin
                    w_fsm_dec = 1'b1;
                end
            end
            INT: begin
                if (r_mode == 2'b01) begin
                    w_fsm_clr_irq = 1'b1;
                    w_next_state  = LOAD;
                end else begin
                    w_fsm_clr_en = 1'b1;
                    w_next_state = IDLE;
                end
            end
            default: w_next_state = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // CTRL fields; a CPU write beats the one-shot auto-disable landing in the same cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_en   <= 1'b0;
            r_mode <= 2'b00;
            r_im   <= 1'b0;
        end else if (w_ctrl_wr) begin
            r_en   <= wdata[0];
            r_mode <= wdata[2:1];
            r_im   <= wdata[3];
        end else if (w_fsm_clr_en) begin
            r_en   <= 1'b0;
        end
    end

    // PRESET holds the reload value; bits above WIDTH are dropped.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_preset <= '0;
        end else if (w_preset_wr) begin
            r_preset <= w_preset_merged[WIDTH-1:0];
        end
    end

    // COUNT loads from PRESET and decrements only while nonzero, so it never wraps.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_count <= '0;
        end else if (w_fsm_load) begin
            r_count <= r_preset;
        end else if (w_fsm_dec) begin
            r_count <= r_count - WIDTH'(1);
        end
    end

    // Interrupt flag: expiry sets it and wins over a CTRL write or auto-reload clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_irq_flag <= 1'b0;
        end else if (w_fsm_set_irq) begin
            r_irq_flag <= 1'b1;
        end else if (w_ctrl_wr || w_fsm_clr_irq) begin
            r_irq_flag <= 1'b0;
        end
    end

endmodule

// File: tb/tb_timer_counter.sv
// tb_timer_counter: directed bench for timer_counter, one task per scenario.
module tb_timer_counter;

    logic        clk;
    logic        reset;
    logic [1:0]  addr;
    logic        we;
    logic [3:0]  byte_en;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        irq;

    int vectors;
    int miscompares;

    timer_counter #(.WIDTH(32)) dut (
        .clk     (clk),
        .reset   (reset),
        .addr    (addr),
        .we      (we),
        .byte_en (byte_en),
        .wdata   (wdata),
        .rdata   (rdata),
        .irq     (irq)
    );

    // 10 ns clock, rising edges at 5, 15, 25, ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Advance one rising edge and settle 1 ns past it before sampling or driving.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One-cycle bus store; the write lands on the edge inside this task.
    task automatic cpuWrite(input logic [1:0] a, input logic [3:0] be, input logic [31:0] d);
        addr    = a;
        we      = 1'b1;
        byte_en = be;
        wdata   = d;
        tick();
        we      = 1'b0;
        byte_en = 4'b0000;
        wdata   = '0;
    endtask

    // Combinational read of one register.
    task automatic readReg(input logic [1:0] a, output logic [31:0] d);
        addr = a;
        #1;
        d = rdata;
    endtask

    // Hold reset over two edges, then release it away from an edge.
    task automatic applyReset();
        reset = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    // After reset every register reads zero and irq is low.
    task automatic test_reset();
        logic [31:0] d;
        applyReset();
        for (int a = 0; a < 4; a++) begin
            readReg(2'(a), d);
            vectors++;
            if (d !== 32'd0) begin
                miscompares++;
                $display("[TB] FAIL reset_rdata addr=%0d got=%h exp=%h", a, d, 32'd0);
            end
        end
        vectors++;
        if (irq !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL reset_irq got=%b exp=0", irq);
        end
    endtask

    // One-shot, PRESET=5: COUNT walks 5..0, irq sets one edge after COUNT reaches 0, EN self-clears.
    task automatic test_one_shot();
        logic [31:0] d;
        applyReset();
        cpuWrite(2'd1, 4'hF, 32'd5);
        cpuWrite(2'd0, 4'hF, 32'h9);
        tick();
        for (int k = 0; k <= 5; k++) begin
            tick();
            readReg(2'd2, d);
            vectors++;
            if (d !== 32'(5 - k)) begin
                miscompares++;
                $display("[TB] FAIL oneshot_count step=%0d got=%0d exp=%0d", k, d, 5 - k);
            end
            if (k < 5) begin
                vectors++;
                if (irq !== 1'b0) begin
                    miscompares++;
                    $display("[TB] FAIL oneshot_irq_early step=%0d got=%b exp=0", k, irq);
                end
            end
        end
        tick();
        vectors++;
        if (irq !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL oneshot_irq_rise got=%b exp=1", irq);
        end
        tick();
        readReg(2'd0, d);
        vectors++;
        if (d !== 32'h8) begin
            miscompares++;
            $display("[TB] FAIL oneshot_ctrl_en_cleared got=%h exp=%h", d, 32'h8);
        end
        tick();
        vectors++;
        if (irq !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL oneshot_irq_sticky got=%b exp=1", irq);
        end
        cpuWrite(2'd0, 4'hF, 32'h8);
        vectors++;
        if (irq !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL oneshot_irq_clear got=%b exp=0", irq);
        end
    endtask

    // Auto-reload, PRESET=2: one-cycle pulse every 5 cycles, first on the 5th edge after enable.
    task automatic test_auto_reload();
        int pulses;
        pulses = 0;
        applyReset();
        cpuWrite(2'd1, 4'hF, 32'd2);
        cpuWrite(2'd0, 4'hF, 32'hB);
        for (int k = 1; k <= 20; k++) begin
            tick();
            if (irq === 1'b1) pulses++;
            vectors++;
            if (irq !== ((k % 5) == 0)) begin
                miscompares++;
                $display("[TB] FAIL reload_irq cycle=%0d got=%b exp=%b", k, irq, (k % 5) == 0);
            end
        end
        vectors++;
        if (pulses != 4) begin
            miscompares++;
            $display("[TB] FAIL reload_pulse_count got=%0d exp=4", pulses);
        end
    endtask

    // Masked one-shot, PRESET=1: irq never rises; a byte-1-only CTRL write changes nothing.
    task automatic test_mask();
        logic [31:0] d;
        applyReset();
        cpuWrite(2'd1, 4'hF, 32'd1);
        cpuWrite(2'd0, 4'hF, 32'h1);
        cpuWrite(2'd0, 4'b0010, 32'h0);
        tick();
        tick();
        readReg(2'd0, d);
        vectors++;
        if (d !== 32'h1) begin
            miscompares++;
            $display("[TB] FAIL mask_ctrl_before got=%h exp=%h", d, 32'h1);
        end
        for (int k = 0; k < 2; k++) begin
            tick();
            vectors++;
            if (irq !== 1'b0) begin
                miscompares++;
                $display("[TB] FAIL mask_irq step=%0d got=%b exp=0", k, irq);
            end
        end
        readReg(2'd0, d);
        vectors++;
        if (d !== 32'h0) begin
            miscompares++;
            $display("[TB] FAIL mask_ctrl_after got=%h exp=%h", d, 32'h0);
        end
    endtask

    // PRESET=10: disable lands as COUNT becomes 6, COUNT freezes, re-enable reloads new PRESET=3.
    task automatic test_pause_resume();
        logic [31:0] d;
        applyReset();
        cpuWrite(2'd1, 4'hF, 32'd10);
        cpuWrite(2'd0, 4'hF, 32'h1);
        for (int k = 0; k < 5; k++) tick();
        readReg(2'd2, d);
        vectors++;
        if (d !== 32'd7) begin
            miscompares++;
            $display("[TB] FAIL pause_count_pre got=%0d exp=7", d);
        end
        cpuWrite(2'd0, 4'hF, 32'h0);
        for (int k = 0; k < 5; k++) begin
            tick();
            readReg(2'd2, d);
            vectors++;
            if (d !== 32'd6) begin
                miscompares++;
                $display("[TB] FAIL pause_count_hold step=%0d got=%0d exp=6", k, d);
            end
        end
        cpuWrite(2'd1, 4'hF, 32'd3);
        cpuWrite(2'd0, 4'hF, 32'h1);
        tick();
        tick();
        readReg(2'd2, d);
        vectors++;
        if (d !== 32'd3) begin
            miscompares++;
            $display("[TB] FAIL resume_reload got=%0d exp=3", d);
        end
    endtask

    // PRESET=0 expiry timing, byte-masked PRESET write, and async reset mid-count.
    task automatic test_boundaries();
        logic [31:0] d;
        applyReset();
        cpuWrite(2'd0, 4'hF, 32'h9);
        tick();
        tick();
        vectors++;
        if (irq !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL zero_irq_early got=%b exp=0", irq);
        end
        tick();
        vectors++;
        if (irq !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL zero_irq_rise got=%b exp=1", irq);
        end
        cpuWrite(2'd1, 4'b0001, 32'hFFFF_FFFF);
        readReg(2'd1, d);
        vectors++;
        if (d !== 32'h0000_00FF) begin
            miscompares++;
            $display("[TB] FAIL preset_byte_en got=%h exp=%h", d, 32'h0000_00FF);
        end
        cpuWrite(2'd0, 4'hF, 32'h9);
        for (int k = 0; k < 4; k++) tick();
        readReg(2'd2, d);
        vectors++;
        if (d !== 32'hFD) begin
            miscompares++;
            $display("[TB] FAIL reset_midcount_pre got=%h exp=%h", d, 32'hFD);
        end
        #1;
        reset = 1'b1;
        readReg(2'd2, d);
        vectors++;
        if (d !== 32'd0) begin
            miscompares++;
            $display("[TB] FAIL reset_async_count got=%h exp=0", d);
        end
        readReg(2'd0, d);
        vectors++;
        if (d !== 32'd0) begin
            miscompares++;
            $display("[TB] FAIL reset_async_ctrl got=%h exp=0", d);
        end
        vectors++;
        if (irq !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL reset_async_irq got=%b exp=0", irq);
        end
        tick();
        reset = 1'b0;
    endtask

    // Scenario sequence and summary.
    initial begin
        vectors     = 0;
        miscompares = 0;
        reset       = 1'b1;
        addr        = 2'd0;
        we          = 1'b0;
        byte_en     = 4'b0000;
        wdata       = '0;
        test_reset();
        test_one_shot();
        test_auto_reload();
        test_mask();
        test_pause_resume();
        test_boundaries();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
